// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        ID_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] ID_instr,
  output logic [31:0] ID_pc,
  output logic [31:0] ID_pc4,
  output logic        ID_valid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic [31:0] r_hold_buf;
  logic [31:0] r_hold_pc;
  logic [31:0] r_drain_addr;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;
  logic        r_id_valid;

  logic [31:0] w_target;
  logic [31:0] w_pc4;
  logic [31:0] w_addr;

  assign w_target  = {br_target[31:2], 2'b00};
  assign w_pc4     = r_pc + 32'd4;
  // A redirected but still outstanding fetch keeps its original address until it completes.
  assign w_addr    = (r_state == DRAIN) ? r_drain_addr : r_pc;
  assign imem_addr = {w_addr[31:2], 2'b00};
  assign imem_req  = r_req;
  assign ID_instr  = r_id_instr;
  assign ID_pc     = r_id_pc;
  assign ID_pc4    = r_id_pc4;
  assign ID_valid  = r_id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_req        <= 1'b0;
      r_pc         <= RESET_PC;
      r_hold_buf   <= 32'd0;
      r_hold_pc    <= 32'd0;
      r_drain_addr <= 32'd0;
      r_id_instr   <= NOP_WORD;
      r_id_pc      <= 32'd0;
      r_id_pc4     <= 32'd0;
      r_id_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= REQ;
          r_req   <= 1'b1;
        end
        REQ: begin
          if (br_taken) begin
            r_pc       <= w_target;
            r_id_instr <= NOP_WORD;
            r_id_valid <= 1'b0;
            if (!imem_ready) begin
              r_drain_addr <= r_pc;
              r_state      <= DRAIN;
            end
          end else if (imem_ready && !ID_stall) begin
            r_id_instr <= imem_rdata;
            r_id_pc    <= r_pc;
            r_id_pc4   <= w_pc4;
            r_id_valid <= 1'b1;
            r_pc       <= w_pc4;
          end else if (imem_ready) begin
            // Decode is frozen: park the word so it is neither lost nor refetched.
            r_hold_buf <= imem_rdata;
            r_hold_pc  <= r_pc;
            r_pc       <= w_pc4;
            r_state    <= HOLD;
            r_req      <= 1'b0;
          end else if (!ID_stall) begin
            r_id_instr <= NOP_WORD;
            r_id_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (br_taken) begin
            r_pc       <= w_target;
            r_id_instr <= NOP_WORD;
            r_id_valid <= 1'b0;
            r_state    <= REQ;
            r_req      <= 1'b1;
          end else if (!ID_stall) begin
            r_id_instr <= r_hold_buf;
            r_id_pc    <= r_hold_pc;
            r_id_pc4   <= r_hold_pc + 32'd4;
            r_id_valid <= 1'b1;
            r_state    <= REQ;
            r_req      <= 1'b1;
          end
        end
        DRAIN: begin
          r_id_instr <= NOP_WORD;
          r_id_valid <= 1'b0;
          if (br_taken) r_pc <= w_target;
          if (imem_ready) r_state <= REQ;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready, ID_stall, br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, ID_instr, ID_pc, ID_pc4;
  logic        ID_valid;

  logic        w2_req;
  logic [31:0] w2_addr, w2_rdata, w2_instr, w2_pc, w2_pc4;
  logic        w2_valid;
  logic        w2_ready = 1'b1;
  logic        w2_stall = 1'b0;
  logic        w2_br = 1'b0;
  logic [31:0] w2_target = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'hE3A0_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_rdata = mw(imem_addr);
  assign w2_rdata   = mw(w2_addr);

  always #5 clk = ~clk;

  if_fetch_stage u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .ID_stall(ID_stall),
    .br_taken(br_taken), .br_target(br_target), .ID_instr(ID_instr),
    .ID_pc(ID_pc), .ID_pc4(ID_pc4), .ID_valid(ID_valid)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .imem_req(w2_req), .imem_addr(w2_addr),
    .imem_rdata(w2_rdata), .imem_ready(w2_ready), .ID_stall(w2_stall),
    .br_taken(w2_br), .br_target(w2_target), .ID_instr(w2_instr),
    .ID_pc(w2_pc), .ID_pc4(w2_pc4), .ID_valid(w2_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decode consumes the IF/ID slot on each edge where it is valid, not stalled, not flushed.
  always @(negedge clk) begin
    if (!reset && ID_valid && !ID_stall && !br_taken) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pc", ID_pc, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", ID_pc, e);
        check("sb_instr", ID_instr, mw(e));
        check("sb_pc4", ID_pc4, e + 32'd4);
      end
    end
  end

  initial begin
    reset = 1'b1; imem_ready = 1'b1; ID_stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);  exp_q.push_back(32'h10);
    step(); step();
    check("rst_instr", ID_instr, 32'd0);
    check("rst_pc", ID_pc, 32'd0);
    check("rst_pc4", ID_pc4, 32'd0);
    check("rst_valid", {31'd0, ID_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("wrap_rst_addr", w2_addr, 32'hFFFF_FFFC);
    reset = 1'b0;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    step();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'd0);
    check("wrap_first_addr", w2_addr, 32'hFFFF_FFFC);
    step();
    check("s2_instr0", ID_instr, 32'hE3A0_0000);
    check("s2_valid0", {31'd0, ID_valid}, 32'd1);
    check("wrap_pc", w2_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", w2_pc4, 32'd0);
    check("wrap_instr", w2_instr, mw(32'hFFFF_FFFC));
    check("wrap_addr", w2_addr, 32'd0);
    step();
    check("s2_instr1", ID_instr, 32'hE3A0_0001);
    step();
    check("s2_instr2", ID_instr, 32'hE3A0_0002);
    check("s2_pc4_2", ID_pc4, 32'hC);
    ID_stall = 1'b1;
    step();
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_pc_a", ID_pc, 32'h8);
    step();
    check("hold_pc_b", ID_pc, 32'h8);
    ID_stall = 1'b0;
    step();
    check("unhold_pc", ID_pc, 32'hC);
    check("unhold_addr", imem_addr, 32'h10);
    step();
    check("after_hold_pc", ID_pc, 32'h10);
    imem_ready = 1'b0;
    step();
    check("wait_valid", {31'd0, ID_valid}, 32'd0);
    check("wait_addr", imem_addr, 32'h14);
    br_taken = 1'b1; br_target = 32'h103;
    exp_q.push_back(32'h100);
    step();
    br_taken = 1'b0;
    check("drain_addr_a", imem_addr, 32'h14);
    check("drain_req", {31'd0, imem_req}, 32'd1);
    check("drain_valid", {31'd0, ID_valid}, 32'd0);
    step();
    check("drain_addr_b", imem_addr, 32'h14);
    imem_ready = 1'b1;
    step();
    check("redirect_addr", imem_addr, 32'h100);
    check("redirect_instr", ID_instr, 32'd0);
    step();
    check("target_pc", ID_pc, 32'h100);
    check("target_instr", ID_instr, 32'hE3A0_0040);
    step();
    ID_stall = 1'b1;
    step();
    br_taken = 1'b1; br_target = 32'h200;
    check("hb_req", {31'd0, imem_req}, 32'd0);
    check("hb_pc", ID_pc, 32'h104);
    step();
    br_taken = 1'b0; ID_stall = 1'b0;
    exp_q.push_back(32'h200);
    check("hb_valid", {31'd0, ID_valid}, 32'd0);
    check("hb_instr", ID_instr, 32'd0);
    check("hb_addr", imem_addr, 32'h200);
    step();
    check("hb_target_pc", ID_pc, 32'h200);
    step();
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'd0, ID_valid}, 32'd0);
    check("midrst_instr", ID_instr, 32'd0);
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_addr", imem_addr, 32'd0);
    check("sb_leftover", exp_q.size(), 32'd0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
